sr_display_scan_driver: RTL and testbench

- Parametrised serial driver for a multiplexed N-digit seven-segment display behind a cascaded 74HC595-style shift-register chain.
- Each digit is scanned in turn: the block shifts a frame of segment bits plus a one-hot digit select over sclk/dio, then pulses rclk to latch it.
- It generalises the fixed 4-digit/8-segment serial driver with:
  - a configurable digit count, segment width, bit order and output polarities;
  - per-digit blanking;
  - coherent frame snapshots;
  - an internal sclk divider, so it runs directly on the system clock.
- It sits between the top-level display outputs and the board PMOD pins.

---
 rtl/sr_display_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_sr_display_scan_driver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sr_display_scan_driver.sv
// Serial scan driver for a multiplexed seven-segment display behind a 74HC595-style chain.
// Each digit frame {segments, one-hot select} is shifted out on sclk/dio, then latched with rclk.
module sr_display_scan_driver #(
  parameter int clk_mhz          = 100,
  parameter int sclk_khz         = 500,
  parameter int w_digit          = 4,
  parameter int w_seg            = 8,
  parameter bit msb_first        = 1'b1,
  parameter bit seg_active_low   = 1'b0,
  parameter bit digit_active_low = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [w_digit*w_seg-1:0]   abcdefgh,
  input  logic [w_digit-1:0]         digit_en,
  output logic                       sclk,
  output logic                       rclk,
  output logic                       dio,
  output logic                       load_enable,
  output logic                       frame_done
);

  localparam int DIV_RAW = (clk_mhz * 1000) / (2 * sclk_khz);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int W       = w_seg + w_digit;
  localparam int IW      = $clog2(W);
  localparam int KW      = (w_digit > 1) ? $clog2(w_digit) : 1;

  typedef enum logic [2:0] {RESET_IDLE, LOAD, SHIFT_HI, SHIFT_LO, LATCH, GAP} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [KW-1:0]              k_q, k_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [W-1:0]               frame_q, frame_d;
  logic [w_digit*w_seg-1:0]   snap_seg_q, snap_seg_d;
  logic [w_digit-1:0]         snap_en_q, snap_en_d;
  logic                       sclk_q, sclk_d, rclk_q, rclk_d, dio_q, dio_d;
  logic                       load_q, load_d, done_q, done_d;
  logic                       tick;

  // Blanking is applied before the polarity inversion, so a blank digit shows all-off.
  function automatic logic [W-1:0] build_frame(input logic [w_digit*w_seg-1:0] segs,
                                               input logic [w_digit-1:0] en,
                                               input logic [KW-1:0] k);
    logic [w_digit*w_seg-1:0] segs_sh;
    logic [w_digit-1:0]       en_sh;
    logic [w_seg-1:0]         seg;
    logic [w_digit-1:0]       sel;
    segs_sh = segs >> (int'(k) * w_seg);
    en_sh   = en >> k;
    seg     = en_sh[0] ? segs_sh[w_seg-1:0] : '0;
    sel     = w_digit'(1) << k;
    return {seg ^ {w_seg{seg_active_low}}, sel ^ {w_digit{digit_active_low}}};
  endfunction

  function automatic logic frame_bit(input logic [W-1:0] frame, input logic [IW-1:0] idx);
    logic [W-1:0] sh;
    sh = msb_first ? (frame >> (W - 1 - int'(idx))) : (frame >> idx);
    return sh[0];
  endfunction

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    logic          enter_load;
    logic [KW-1:0] k_next;
    logic [IW-1:0] idx_inc;
    logic [w_digit*w_seg-1:0] seg_src;
    logic [w_digit-1:0]       en_src;

    state_d    = state_q;
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    k_d        = k_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    snap_seg_d = snap_seg_q;
    snap_en_d  = snap_en_q;
    sclk_d     = sclk_q;
    rclk_d     = rclk_q;
    dio_d      = dio_q;
    load_d     = 1'b0;
    done_d     = 1'b0;
    enter_load = 1'b0;
    k_next     = k_q;
    idx_inc    = idx_q + 1'b1;
    seg_src    = snap_seg_q;
    en_src     = snap_en_q;

    if (tick) begin
      case (state_q)
        RESET_IDLE: enter_load = 1'b1;
        LOAD, SHIFT_LO: begin
          state_d = SHIFT_HI;
          sclk_d  = 1'b1;
        end
        SHIFT_HI: begin
          sclk_d = 1'b0;
          if (idx_q < IW'(W - 1)) begin
            idx_d   = idx_inc;
            state_d = SHIFT_LO;
            dio_d   = frame_bit(frame_q, idx_inc);
          end else begin
            state_d = LATCH;
            rclk_d  = 1'b1;
          end
        end
        LATCH: begin
          state_d = GAP;
          rclk_d  = 1'b0;
        end
        GAP: begin
          if (k_q == KW'(w_digit - 1)) begin
            k_next = '0;
            done_d = 1'b1;
          end else begin
            k_next = k_q + 1'b1;
          end
          enter_load = 1'b1;
        end
        default: state_d = RESET_IDLE;
      endcase
    end

    // Digit 0 takes a fresh snapshot; its frame is built straight from the inputs being captured.
    if (enter_load) begin
      state_d = LOAD;
      k_d     = k_next;
      idx_d   = '0;
      sclk_d  = 1'b0;
      rclk_d  = 1'b0;
      if (k_next == '0) begin
        snap_seg_d = abcdefgh;
        snap_en_d  = digit_en;
        seg_src    = abcdefgh;
        en_src     = digit_en;
        load_d     = 1'b1;
      end
      frame_d = build_frame(seg_src, en_src, k_next);
      dio_d   = frame_bit(frame_d, '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      snap_seg_q <= '0;
      snap_en_q  <= '0;
      sclk_q     <= 1'b0;
      rclk_q     <= 1'b0;
      dio_q      <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      snap_seg_q <= snap_seg_d;
      snap_en_q  <= snap_en_d;
      sclk_q     <= sclk_d;
      rclk_q     <= rclk_d;
      dio_q      <= dio_d;
      load_q     <= load_d;
      done_q     <= done_d;
    end
  end

  assign sclk        = sclk_q;
  assign rclk        = rclk_q;
  assign dio         = dio_q;
  assign load_enable = load_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_sr_display_scan_driver.sv
// Directed bench: three driver instances (default polarity, active-low segments, 1-digit LSB-first)
// share clock and reset; a negedge monitor logs latched frames and pulse timing per instance.
module tb_sr_display_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] abc_a, abc_b;
  logic [3:0]  en_a, en_b;
  logic [7:0]  abc_c;
  logic [0:0]  en_c;
  logic [2:0]  sclk_w, rclk_w, dio_w, le_w, fd_w;

  always #5 clk = ~clk;

  sr_display_scan_driver #(.clk_mhz(4), .sclk_khz(1000)) u_a (
    .clk(clk), .rst(rst), .abcdefgh(abc_a), .digit_en(en_a),
    .sclk(sclk_w[0]), .rclk(rclk_w[0]), .dio(dio_w[0]),
    .load_enable(le_w[0]), .frame_done(fd_w[0]));

  sr_display_scan_driver #(.clk_mhz(4), .sclk_khz(1000), .seg_active_low(1'b1)) u_b (
    .clk(clk), .rst(rst), .abcdefgh(abc_b), .digit_en(en_b),
    .sclk(sclk_w[1]), .rclk(rclk_w[1]), .dio(dio_w[1]),
    .load_enable(le_w[1]), .frame_done(fd_w[1]));

  sr_display_scan_driver #(.clk_mhz(4), .sclk_khz(1000), .w_digit(1), .msb_first(1'b0)) u_c (
    .clk(clk), .rst(rst), .abcdefgh(abc_c), .digit_en(en_c),
    .sclk(sclk_w[2]), .rclk(rclk_w[2]), .dio(dio_w[2]),
    .load_enable(le_w[2]), .frame_done(fd_w[2]));

  int          cyc;
  int          nb[3];
  logic [15:0] acc[3];
  int          nf[3];
  logic [15:0] frm[3][16];
  int          fbits[3][16];
  int          fcyc[3][16];
  int          rhi[3][16];
  int          nle[3];
  int          le_cyc[3][16];
  int          nfd[3];
  int          fd_cyc[3][16];
  int          srise1[3];
  logic [2:0]  psclk, prclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Serial bits are shifted in as they appear, so the earliest bit ends up most significant.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        acc[i] = '0;
        nb[i]  = 0;
      end else begin
        if (sclk_w[i] && !psclk[i]) begin
          acc[i] = {acc[i][14:0], dio_w[i]};
          nb[i]++;
          if (srise1[i] == 0) srise1[i] = cyc;
        end
        if (rclk_w[i] && !prclk[i] && nf[i] < 16) begin
          frm[i][nf[i]]   = acc[i];
          fbits[i][nf[i]] = nb[i];
          fcyc[i][nf[i]]  = cyc;
          rhi[i][nf[i]]   = 0;
          nf[i]++;
          acc[i] = '0;
          nb[i]  = 0;
        end
        if (rclk_w[i] && nf[i] > 0) rhi[i][nf[i]-1]++;
        if (le_w[i] && nle[i] < 16) begin le_cyc[i][nle[i]] = cyc; nle[i]++; end
        if (fd_w[i] && nfd[i] < 16) begin fd_cyc[i][nfd[i]] = cyc; nfd[i]++; end
      end
      psclk[i] = sclk_w[i];
      prclk[i] = rclk_w[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rel;
  int nf_before;

  initial begin
    rst   = 1'b1;
    abc_a = {8'hFF, 8'h00, 8'h3C, 8'hA5};
    en_a  = 4'hF;
    abc_b = {8'h08, 8'h04, 8'h02, 8'h01};
    en_b  = 4'b1011;
    abc_c = 8'h80;
    en_c  = 1'b1;
    repeat (5) step();

    check_eq("reset_outs_a", {27'd0, sclk_w[0], rclk_w[0], dio_w[0], le_w[0], fd_w[0]}, 32'd0);
    check_eq("reset_outs_b", {27'd0, sclk_w[1], rclk_w[1], dio_w[1], le_w[1], fd_w[1]}, 32'd0);
    check_eq("reset_outs_c", {27'd0, sclk_w[2], rclk_w[2], dio_w[2], le_w[2], fd_w[2]}, 32'd0);

    rel = cyc;
    rst = 1'b0;

    for (int t = 0; t < 200 && nf[0] < 1; t++) step();
    check_eq("a_first_latch_seen", 32'(nf[0] >= 1), 32'd1);
    // Digit 1 is mid-shift here; the new pattern must stay invisible until the next scan.
    repeat (10) step();
    abc_a = {8'h44, 8'h33, 8'h22, 8'h11};

    for (int t = 0; t < 600 && nf[0] < 8; t++) step();
    check_eq("a_eight_latches", 32'(nf[0]), 32'd8);

    check_eq("first_load_latency", 32'(le_cyc[0][0] - rel), 32'd3);
    check_eq("first_sclk_after_load", 32'(srise1[0] - le_cyc[0][0]), 32'd2);
    check_eq("load_enable_once_per_scan", 32'(le_cyc[0][1] - le_cyc[0][0]), 32'd208);
    check_eq("a_digit_period", 32'(fcyc[0][1] - fcyc[0][0]), 32'd52);

    check_eq("a_d0_frame", 32'(frm[0][0]), 32'h0A5E);
    check_eq("a_d0_bits", 32'(fbits[0][0]), 32'd12);
    check_eq("a_d0_rclk_width", 32'(rhi[0][0]), 32'd2);
    check_eq("a_scan1_d1_old", 32'(frm[0][1]), 32'h03CD);
    check_eq("a_scan1_d2_old", 32'(frm[0][2]), 32'h000B);
    check_eq("a_scan1_d3_old", 32'(frm[0][3]), 32'h0FF7);
    check_eq("a_scan2_d0_new", 32'(frm[0][4]), 32'h011E);
    check_eq("a_scan2_d1_new", 32'(frm[0][5]), 32'h022D);
    check_eq("a_scan2_d2_new", 32'(frm[0][6]), 32'h033B);
    check_eq("a_scan2_d3_new", 32'(frm[0][7]), 32'h0447);

    check_eq("b_d0_frame", 32'(frm[1][0]), 32'h0FEE);
    check_eq("b_d1_frame", 32'(frm[1][1]), 32'h0FDD);
    check_eq("b_d2_blank", 32'(frm[1][2]), 32'h0FFB);
    check_eq("b_d3_frame", 32'(frm[1][3]), 32'h0F77);
    check_eq("b_frame_done_timing", 32'(fd_cyc[1][0] - le_cyc[1][0]), 32'd208);

    check_eq("c_lsb_frame", 32'(frm[2][0]), 32'h0001);
    check_eq("c_lsb_bits", 32'(fbits[2][0]), 32'd9);
    check_eq("c_load_period", 32'(le_cyc[2][1] - le_cyc[2][0]), 32'd40);
    check_eq("c_done_with_load", 32'(fd_cyc[2][0]), 32'(le_cyc[2][1]));
    check_eq("c_done_period", 32'(fd_cyc[2][1] - fd_cyc[2][0]), 32'd40);

    for (int t = 0; t < 100 && nb[0] != 5; t++) step();
    check_eq("a_five_rises", 32'(nb[0]), 32'd5);
    nf_before = nf[0];
    rst = 1'b1;
    repeat (3) step();
    check_eq("no_latch_on_reset", 32'(nf[0]), 32'(nf_before));
    check_eq("rclk_low_in_reset", {31'd0, rclk_w[0]}, 32'd0);
    rst = 1'b0;
    for (int t = 0; t < 200 && nf[0] <= nf_before; t++) step();
    check_eq("restart_latch_seen", 32'(nf[0]), 32'(nf_before + 1));
    check_eq("restart_d0_frame", 32'(frm[0][nf_before]), 32'h011E);
    check_eq("restart_full_shift", 32'(fbits[0][nf_before]), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
